// File: rtl/moving_average_mc.sv
// Multi-channel boxcar averager: per-channel power-of-two window with an exact running sum,
// two-stage pipeline, optional once-per-window decimated output.
module moving_average_mc #(
  parameter int DATA_IN_BITS  = 12,
  parameter int DATA_OUT_BITS = 12,
  parameter int CHANNELS      = 4,
  parameter int CH_BITS       = 2,
  parameter int AVERAGE_NUM   = 32,
  parameter int AVERAGE_BITS  = 5,
  parameter int DECIMATE      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     data_in_valid,
  input  logic [CH_BITS-1:0]       data_in_channel,
  input  logic [DATA_IN_BITS-1:0]  data_in,
  output logic                     data_out_valid,
  output logic [CH_BITS-1:0]       data_out_channel,
  output logic [DATA_OUT_BITS-1:0] data_out,
  output logic                     data_out_full
);

  localparam int SUM_BITS  = DATA_IN_BITS + AVERAGE_BITS;
  localparam int FILL_BITS = AVERAGE_BITS + 1;
  localparam int ADDR_BITS = CH_BITS + AVERAGE_BITS;
  localparam int DEPTH     = CHANNELS * AVERAGE_NUM;
  localparam logic [FILL_BITS-1:0] FILL_FULL = FILL_BITS'(AVERAGE_NUM);
  localparam logic [CH_BITS:0]     CH_LIMIT  = (CH_BITS + 1)'(CHANNELS);

  logic [DATA_IN_BITS-1:0] history [DEPTH];

  logic [SUM_BITS-1:0]     acc    [CHANNELS];
  logic [FILL_BITS-1:0]    fill   [CHANNELS];
  logic [AVERAGE_BITS-1:0] wr_ptr [CHANNELS];
  logic [AVERAGE_BITS-1:0] phase  [CHANNELS];

  logic                     accept;
  logic [SUM_BITS-1:0]      cur_acc;
  logic [FILL_BITS-1:0]     cur_fill;
  logic [AVERAGE_BITS-1:0]  cur_ptr;
  logic [AVERAGE_BITS-1:0]  cur_phase;
  logic [ADDR_BITS-1:0]     hist_addr;
  logic [DATA_IN_BITS-1:0]  oldest;
  logic [SUM_BITS-1:0]      next_acc;
  logic [FILL_BITS-1:0]     next_fill;
  logic [AVERAGE_BITS-1:0]  next_phase;
  logic                     emit;

  logic                     s1_valid;
  logic [CH_BITS-1:0]       s1_channel;
  logic                     s1_full;
  logic [DATA_OUT_BITS-1:0] s1_avg;

  // A simultaneous clear makes the incoming sample start from an empty window.
  always_comb begin
    accept     = data_in_valid && ({1'b0, data_in_channel} < CH_LIMIT);
    cur_acc    = clear ? '0 : acc[data_in_channel];
    cur_fill   = clear ? '0 : fill[data_in_channel];
    cur_ptr    = clear ? '0 : wr_ptr[data_in_channel];
    cur_phase  = clear ? '0 : phase[data_in_channel];
    hist_addr  = {data_in_channel, cur_ptr};
    oldest     = (cur_fill == FILL_FULL) ? history[hist_addr] : '0;
    next_acc   = cur_acc + SUM_BITS'(data_in) - SUM_BITS'(oldest);
    next_fill  = (cur_fill == FILL_FULL) ? cur_fill : cur_fill + 1'b1;
    next_phase = cur_phase + 1'b1;
    emit       = (DECIMATE == 0) || (next_phase == '0);
  end

  // Read-before-write at the same address; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (accept) begin
      history[hist_addr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc[i]    <= '0;
        fill[i]   <= '0;
        wr_ptr[i] <= '0;
        phase[i]  <= '0;
      end
    end else begin
      if (clear) begin
        for (int i = 0; i < CHANNELS; i++) begin
          acc[i]    <= '0;
          fill[i]   <= '0;
          wr_ptr[i] <= '0;
          phase[i]  <= '0;
        end
      end
      if (accept) begin
        acc[data_in_channel]    <= next_acc;
        fill[data_in_channel]   <= next_fill;
        wr_ptr[data_in_channel] <= cur_ptr + 1'b1;
        phase[data_in_channel]  <= next_phase;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_channel <= '0;
      s1_full    <= 1'b0;
      s1_avg     <= '0;
    end else begin
      s1_valid <= accept && emit;
      if (accept) begin
        s1_channel <= data_in_channel;
        s1_full    <= (next_fill == FILL_FULL);
        s1_avg     <= next_acc[SUM_BITS-1 -: DATA_OUT_BITS];
      end
    end
  end

  // Output fields hold their last value between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_valid   <= 1'b0;
      data_out_channel <= '0;
      data_out         <= '0;
      data_out_full    <= 1'b0;
    end else begin
      data_out_valid <= s1_valid;
      if (s1_valid) begin
        data_out_channel <= s1_channel;
        data_out         <= s1_avg;
        data_out_full    <= s1_full;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_mc.sv
// Bench for moving_average_mc: table vectors plus a windowed-sum reference model feeding
// scoreboards for a per-sample instance and a decimating instance.
module tb_moving_average_mc;

  localparam int CH = 4;
  localparam int N  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        data_in_valid;
  logic [1:0]  data_in_channel;
  logic [11:0] data_in;

  logic        out_valid, dec_valid;
  logic [1:0]  out_channel, dec_channel;
  logic [11:0] out_data, dec_data;
  logic        out_full, dec_full;

  moving_average_mc #(.DECIMATE(0)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .data_in_valid(data_in_valid), .data_in_channel(data_in_channel), .data_in(data_in),
    .data_out_valid(out_valid), .data_out_channel(out_channel),
    .data_out(out_data), .data_out_full(out_full)
  );

  moving_average_mc #(.DECIMATE(1)) dut_dec (
    .clk(clk), .rst(rst), .clear(clear),
    .data_in_valid(data_in_valid), .data_in_channel(data_in_channel), .data_in(data_in),
    .data_out_valid(dec_valid), .data_out_channel(dec_channel),
    .data_out(dec_data), .data_out_full(dec_full)
  );

  always #5 clk = ~clk;

  typedef struct { int ch; int avg; bit full; int cyc; } exp_t;
  typedef struct { int ch; int x; int avg; bit full; } vec_t;

  exp_t q_avg[$];
  exp_t q_dec[$];
  exp_t e_avg, e_dec;
  vec_t vecs[96];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dec_count = 0;
  int win [CH][N];
  int cnt [CH];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < CH; c++) begin
      cnt[c] = 0;
      for (int i = 0; i < N; i++) win[c][i] = 0;
    end
  endtask

  // Reference: keep the last N samples per channel and re-add the whole window each time.
  task automatic modelSample(input int ch, input int x, input bit has_exp,
                             input int exp_avg, input bit exp_full);
    int sum;
    exp_t e;
    win[ch][cnt[ch] % N] = x;
    cnt[ch]++;
    sum = 0;
    for (int i = 0; i < N; i++) sum += win[ch][i];
    e.ch = ch;
    e.cyc = cyc + 2;
    e.avg = has_exp ? exp_avg : sum / N;
    e.full = has_exp ? exp_full : (cnt[ch] >= N);
    q_avg.push_back(e);
    if (cnt[ch] % N == 0) begin
      e.avg = sum / N;
      e.full = 1'b1;
      q_dec.push_back(e);
    end
  endtask

  task automatic applyStimulus(input bit valid, input int ch, input int x, input bit clr,
                               input bit has_exp, input int exp_avg, input bit exp_full);
    @(negedge clk);
    data_in_valid   = valid;
    data_in_channel = ch[1:0];
    data_in         = x[11:0];
    clear           = clr;
    if (clr) modelReset();
    if (valid && ch < CH) modelSample(ch, x, has_exp, exp_avg, exp_full);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (q_avg.size() == 0) begin
        checkOutput("avg_unexpected_valid", 1, 0);
      end else begin
        e_avg = q_avg.pop_front();
        checkOutput("avg_data", int'(out_data), e_avg.avg);
        checkOutput("avg_channel", int'(out_channel), e_avg.ch);
        checkOutput("avg_full", int'(out_full), int'(e_avg.full));
        checkOutput("avg_latency", cyc, e_avg.cyc);
      end
    end
    if (dec_valid) begin
      dec_count++;
      if (q_dec.size() == 0) begin
        checkOutput("dec_unexpected_valid", 1, 0);
      end else begin
        e_dec = q_dec.pop_front();
        checkOutput("dec_data", int'(dec_data), e_dec.avg);
        checkOutput("dec_channel", int'(dec_channel), e_dec.ch);
        checkOutput("dec_full", int'(dec_full), int'(e_dec.full));
        checkOutput("dec_latency", cyc, e_dec.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int consts [CH];
    int dec_start;
    consts = '{0, 1000, 2000, 4095};

    // ch0 warm-up at 100, ch1 warm-up at 100 then slide to 4095
    for (int i = 0; i < 32; i++) vecs[i] = '{0, 100, (100 * (i + 1)) / 32, i == 31};
    for (int i = 0; i < 32; i++) vecs[32 + i] = '{1, 100, (100 * (i + 1)) / 32, i == 31};
    for (int k = 1; k <= 32; k++) vecs[63 + k] = '{1, 4095, (3200 + 3995 * k) / 32, 1'b1};
    vecs[0].avg  = 3;
    vecs[1].avg  = 6;
    vecs[2].avg  = 9;
    vecs[31].avg = 100;
    vecs[79].avg = 2097;
    vecs[95].avg = 4095;

    rst = 1'b1;
    clear = 1'b0;
    data_in_valid = 1'b0;
    data_in_channel = '0;
    data_in = '0;
    modelReset();
    #12;
    checkOutput("reset_valid", int'(out_valid), 0);
    checkOutput("reset_channel", int'(out_channel), 0);
    checkOutput("reset_data", int'(out_data), 0);
    checkOutput("reset_full", int'(out_full), 0);
    checkOutput("reset_dec_valid", int'(dec_valid), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 96; i++)
      applyStimulus(1'b1, vecs[i].ch, vecs[i].x, 1'b0, 1'b1, vecs[i].avg, vecs[i].full);

    for (int r = 0; r < 32; r++)
      for (int c = 0; c < CH; c++)
        applyStimulus(1'b1, c, consts[c], 1'b0, r == 31, consts[c], 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 0, 1'b0);
    dec_start = dec_count;
    for (int i = 0; i < 96; i++) applyStimulus(1'b1, 2, 500, 1'b0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("dec_output_count", dec_count - dec_start, 3);

    for (int i = 0; i < 32; i++) applyStimulus(1'b1, 0, 100, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 0, 800, 1'b1, 1'b1, 25, 1'b0);
    applyStimulus(1'b1, 2, 320, 1'b0, 1'b1, 10, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

    // Reset lands while a sample sits in stage 1; it must never come out.
    applyStimulus(1'b1, 3, 4000, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    q_avg.delete();
    q_dec.delete();
    modelReset();
    #1;
    checkOutput("async_rst_valid", int'(out_valid), 0);
    checkOutput("async_rst_channel", int'(out_channel), 0);
    checkOutput("async_rst_data", int'(out_data), 0);
    checkOutput("async_rst_full", int'(out_full), 0);
    @(negedge clk);
    data_in_valid = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b1, 3, 320, 1'b0, 1'b1, 10, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20 && (q_avg.size() > 0 || q_dec.size() > 0); i++) @(negedge clk);
    checkOutput("scoreboard_drained", q_avg.size() + q_dec.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/moving_average_mc.md
# moving_average_mc

Multi-channel, full-precision boxcar averager for time-multiplexed ADC sample streams. It keeps one power-of-two window of history per channel and an exact running sum with no per-sample truncation. It emits a tagged average either for every sample or once per completed window (decimated). It sits after the ADC capture/demux stage and feeds the downstream filtering and readout logic.

## Interface
- `DATA_IN_BITS`, 12, unsigned input sample width
- `DATA_OUT_BITS`, 12, output width; 1 ≤ value ≤ `DATA_IN_BITS + AVERAGE_BITS`
- `CHANNELS`, 4, number of interleaved channels, ≥ 1
- `CH_BITS`, 2, channel index width; 2^`CH_BITS` ≥ `CHANNELS`
- `AVERAGE_NUM`, 32, window length; must equal 2^`AVERAGE_BITS`
- `AVERAGE_BITS`, 5, log2 of window length, ≥ 1
- `DECIMATE`, 0, 0 = output on every accepted sample; 1 = output once per `AVERAGE_NUM` samples of a channel
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `clear` in 1: synchronous flush of all channel windows
- `data_in_valid` in 1: sample strobe; no back-pressure, so every valid cycle is accepted
- `data_in_channel` in `CH_BITS`: channel tag of `data_in`
- `data_in` in `DATA_IN_BITS`: unsigned sample
- `data_out_valid` out 1: one-cycle strobe per output
- `data_out_channel` out `CH_BITS`: channel tag of `data_out`
- `data_out` out `DATA_OUT_BITS`: averaged value
- `data_out_full` out 1: the window for `data_out_channel` held `AVERAGE_NUM` samples when the output was produced

## Operation
- Per-channel state:
  - history ring of `AVERAGE_NUM` × `DATA_IN_BITS`
  - write pointer, `AVERAGE_BITS` bits, wraps modulo `AVERAGE_NUM`
  - fill counter, saturating at `AVERAGE_NUM`
  - accumulator of `SUM_BITS = DATA_IN_BITS + AVERAGE_BITS` bits, unsigned, exact; it never overflows
  - decimation phase counter, `AVERAGE_BITS` bits
- Accepted sample `x` on channel `c`:
  - `oldest = history[c][wr_ptr[c]]` if `fill[c] == AVERAGE_NUM`, else 0
  - `acc[c] <= acc[c] + x - oldest`
  - `history[c][wr_ptr[c]] <= x`
  - `wr_ptr[c]++`, `fill[c]` increments and saturates, `phase[c]++`
- Output value: `data_out = acc[SUM_BITS-1 -: DATA_OUT_BITS]`, the MSB slice. With `DATA_OUT_BITS == DATA_IN_BITS` this equals floor(sum / `AVERAGE_NUM`). No rounding, no saturation.
- Warm-up: while `fill < AVERAGE_NUM` the output is the partial sum scaled by 1/`AVERAGE_NUM`, not by 1/fill, and `data_out_full` = 0.
- `DECIMATE=1`:
  - output is emitted only for the sample that makes `phase[c]` wrap to 0, i.e. the 32nd, 64th, … sample of the channel
  - warm-up outputs are therefore suppressed except the first wrap, which is full
- Channel index ≥ `CHANNELS`: sample ignored, no state change, no output.
- `clear`:
  - zeroes every acc, fill, wr_ptr and phase
  - history RAM is not cleared; fill = 0 masks stale entries
  - if `data_in_valid` is high in the same cycle, the sample is the first entry of the fresh window: acc = x, fill = 1, phase = 1, and its output is produced per mode
- `rst`, asynchronous, takes effect immediately, including mid-pipeline:
  - zeroes acc, fill, wr_ptr, phase and the pipeline valid
  - outputs go to `data_out_valid`=0, `data_out_channel`=0, `data_out`=0, `data_out_full`=0
  - in-flight samples are dropped
- History storage is inferable as distributed/block RAM: one write per cycle, and the read address equals the write address, read-before-write.

## Timing
- Stage 1 (edge after `data_in_valid`): acc, history, pointers updated; channel, full flag and emit decision registered.
- Stage 2: `data_out*` registered from the updated acc.
- Latency: sample valid in cycle n → `data_out_valid` in cycle n+2, for every accepted sample in `DECIMATE=0`.
- Throughput: one sample per cycle. Any channel order is allowed, including the same channel on consecutive cycles; acc is register-resident, so no hazard stall is needed.
- `data_out_valid` is high for exactly one cycle per output. `data_out`, `data_out_channel` and `data_out_full` hold their last values when it is low.
- `clear` in cycle n affects state at the end of cycle n. Outputs already in stage 2 still emit.

## Test plan
- Warm-up, `DECIMATE=0`: ch0 receives 32 samples of 100. Outputs ramp 3, 6, 9, …, final value 100. `data_out_full` is first 1 on sample 32. Each output appears 2 cycles after its input.
- Steady-state slide: after 32×100 on ch1, send 32×4095. Output rises to 4095 exactly, with no truncation drift: the 16th output is floor((16·100 + 16·4095)/32) = 2097.
- Interleave: channels 0..3 round-robin with constants 0, 1000, 2000, 4095 for 128 cycles. Each channel's full output equals its constant. Tags are correct, with no cross-channel leakage.
- Decimation, `DECIMATE=1`: 96 samples of 500 on ch2 give exactly 3 outputs of 500, after samples 32, 64 and 96, all with full=1.
- `clear` plus a simultaneous sample 800 on ch0 after steady state at 100 → output 25 (800/32) with full=0. The other channels restart at zero.
- Async `rst` asserted between input and output → no `data_out_valid`, all outputs 0 immediately. After release, averaging restarts from an empty window.
